decade_count_monitor: RTL and testbench
=======================================

# decade_count_monitor

Checker and decoder that sits on the output of an up/down decade counter. It samples the counter's 4-bit BCD value and direction select, predicts each next value, and flags illegal or out-of-sequence transitions. It also reconstructs a two-digit 00–99 value by tracking units wrap-around into a tens digit. It is the consuming end of the counter interface, used in-system as a health monitor and in benches as a self-checking scoreboard.

## Interface
- `ERR_W`, default 8: width of the saturating error counter.
- `clk` input 1: rising-edge clock; same clock as the monitored counter.
- `reset` input 1: asynchronous, active-low reset.
- `sample_en` input 1: when high, `count_in`/`sel_in` are sampled this edge.
- `count_in` input 4: observed BCD count.
- `sel_in` input 1: observed direction select; 0 = up, 1 = down.
- `tens` output 4: reconstructed tens digit, BCD.
- `units` output 4: last accepted units digit.
- `locked` output 1: high while in TRACK.
- `err` output 1: one-cycle pulse on a detected violation.
- `err_count` output ERR_W: saturating violation count.
- `wrap_up` output 1: one-cycle pulse on a legal 9→0 step while counting up.
- `wrap_dn` output 1: one-cycle pulse on a legal 0→9 step while counting down.
- `seg_units` output 7: registered seven-segment code, gfedcba, active-high. Present only with the macro.
- `seg_tens` output 7: as `seg_units`, for the tens digit. Present only with the macro.

## Operation
- The monitor holds `prev` (4 bits) and `sel_prev` (1 bit). The next count equals f(count_k, sel_k), so the prediction uses the registered select, not the current `sel_in`.
- Prediction:
  - `sel_prev`=0: `exp` = `prev`==9 ? 0 : `prev`+1.
  - `sel_prev`=1: `exp` = `prev`==0 ? 9 : `prev`−1.
- FSM with two states: ACQUIRE (reset state) and TRACK.
- ACQUIRE, on `sample_en`:
  - `count_in` ≤ 9: load `prev`/`sel_prev`/`units`, then go to TRACK. This is not a check and raises no `err`.
  - `count_in` > 9: `err` pulse, `err_count`++, stay in ACQUIRE.
- TRACK, on `sample_en`:
  - `count_in` == `exp`: accept. Update `prev`, `units` and `sel_prev`.
    - `wrap_up` when `prev`=9, `sel_prev`=0, `count_in`=0; `tens` increments, 9→0.
    - `wrap_dn` when `prev`=0, `sel_prev`=1, `count_in`=9; `tens` decrements, 0→9.
  - `count_in` ≤ 9 but ≠ `exp`: `err`, `err_count`++. Resync: `prev`/`units` take `count_in`, `sel_prev` takes `sel_in`. Stay in TRACK, `tens` unchanged. A single disturbance (e.g. counter reset) yields exactly one error.
  - `count_in` > 9: `err`, `err_count`++, go to ACQUIRE. `prev`, `units` and `tens` are held.
- `sample_en` low: no state change; all pulses low.
- `err_count` saturates at 2^ERR_W−1; `err` still pulses at saturation.
- A direction change is legal on any sample. The step after it follows the new `sel_prev`.

## Timing
- All outputs are registered. Pulses and state updates appear on the edge that samples the input, so they are visible in the cycle following sample presentation.
- Reset values: state=ACQUIRE, `tens`=0, `units`=0, `prev`=0, `sel_prev`=0, `locked`=0, `err`=0, `wrap_up`=0, `wrap_dn`=0, `err_count`=0, `seg_units`=`seg_tens`=7'h3F.
- Reset assertion mid-operation clears everything immediately, independent of `clk`.
- Monitored at full rate: `sample_en` tied high, one sample per clock.

## Configuration
- Macro: `DECADE_MON_SEG_EN`.
- Defined: the `seg_units`/`seg_tens` ports exist.
  - Each is registered from the next-state `units`/`tens` and updates in the same cycle as the digit.
  - Digits 0–9 use the standard codes. Any value > 9 displays the dash code 7'h40.
- Undefined: ports and decoder logic are absent; all other behaviour is identical.

## Structure
- Package `decade_mon_pkg` holds:
  - the state enum (ACQUIRE, TRACK);
  - `DIGIT_MAX`=4'd9;
  - `SEG_BLANK_ZERO`=7'h3F;
  - `SEG_DASH`=7'h40.
- Sub-module `bcd_to_seg7`:
  - combinational BCD to 7-segment conversion;
  - instantiated twice under the macro;
  - its outputs are registered in the parent.

## Test plan
- Reset, then up-count 0..9,0,1 with `sel_in`=0 → `locked`=1 after the first sample, no `err`, one `wrap_up` at the 9→0 sample, `tens`=1, `units`=1.
- Down-count 2,1,0,9,8 with `sel_in`=1 from `tens`=1 → one `wrap_dn` at 0→9, `tens`=0, `units`=8, no `err`.
- Up sequence 3,4,7,8 → single `err` at 7, `err_count`=1, resync; 8 accepted with no further error.
- Inject `count_in`=4'hC while in TRACK → `err`, `locked`=0, state ACQUIRE. Next legal value 5 relocks without error; `tens` is retained.
- Force 260 illegal samples with ERR_W=8 → `err_count` holds 255; `err` pulses every sample.
- Assert `reset` while `tens`=3 mid-count → all outputs return to reset values asynchronously. With `DECADE_MON_SEG_EN`, both `seg` outputs read 7'h3F.

Source files
------------

// File: rtl/decade_mon_pkg.sv
// decade_mon_pkg: shared types and constants for the decade counter monitor.
//   mon_state_e    - monitor FSM states (ACQUIRE, TRACK)
//   DIGIT_MAX      - largest legal BCD digit
//   SEG_BLANK_ZERO - seven-segment code for "0" (reset display)
//   SEG_DASH       - seven-segment code shown for non-BCD values
//   bcd_step()     - one decade step up or down with wrap
package decade_mon_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } mon_state_e;

  localparam logic [3:0] DIGIT_MAX      = 4'd9;
  localparam logic [6:0] SEG_BLANK_ZERO = 7'h3F;
  localparam logic [6:0] SEG_DASH       = 7'h40;

  // Next value of a decade counter: down=0 counts 0..9 up, down=1 counts 9..0.
  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic down);
    if (down) return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
    else      return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to seven-segment decoder.
//   digit : 4-bit BCD input
//   seg   : gfedcba, active-high; values above 9 show a dash
module bcd_to_seg7
  import decade_mon_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_BLANK_ZERO;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/decade_count_monitor.sv
// decade_count_monitor: checker/decoder on the output of an up/down decade
// counter. Predicts each next count from the previously accepted count and
// the previously sampled direction, flags illegal or out-of-sequence values,
// and rebuilds a 00-99 value by tracking unit wraps into a tens digit.
//
// Optional feature macro: DECADE_MON_SEG_EN adds registered seven-segment
// outputs for both digits.
//
// Ports:
//   clk        - rising-edge clock (same as monitored counter)
//   reset      - asynchronous active-low reset
//   sample_en  - sample count_in/sel_in on this edge
//   count_in   - observed BCD count
//   sel_in     - observed direction, 0 = up, 1 = down
//   tens       - reconstructed tens digit
//   units      - last accepted units digit
//   locked     - high while tracking
//   err        - one-cycle pulse per detected violation
//   err_count  - saturating violation count
//   wrap_up    - one-cycle pulse on a legal 9->0 up step
//   wrap_dn    - one-cycle pulse on a legal 0->9 down step
//   seg_units  - (macro only) seven-segment code of units
//   seg_tens   - (macro only) seven-segment code of tens
module decade_count_monitor
  import decade_mon_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [3:0]       count_in,
  input  logic             sel_in,
  output logic [3:0]       tens,
  output logic [3:0]       units,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_up,
`ifdef DECADE_MON_SEG_EN
  output logic             wrap_dn,
  output logic [6:0]       seg_units,
  output logic [6:0]       seg_tens
`else
  output logic             wrap_dn
`endif
);

  mon_state_e       state, state_nx;
  logic [3:0]       prev, prev_nx;
  logic             sel_prev, sel_nx;
  logic [3:0]       units_nx, tens_nx;
  logic             err_nx, wrap_up_nx, wrap_dn_nx;
  logic [ERR_W-1:0] err_count_nx;
  logic [3:0]       exp_val;
  logic             legal;

  // The counter's next value depends on the select it saw with the current
  // value, so predict from the registered select rather than sel_in.
  assign exp_val = bcd_step(prev, sel_prev);
  assign legal   = (count_in <= DIGIT_MAX);
  assign locked  = (state == TRACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACQUIRE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    prev_nx      = prev;
    sel_nx       = sel_prev;
    units_nx     = units;
    tens_nx      = tens;
    err_nx       = 1'b0;
    wrap_up_nx   = 1'b0;
    wrap_dn_nx   = 1'b0;
    err_count_nx = err_count;
    if (sample_en) begin
      if (!legal) begin
        // Non-BCD value: drop lock, hold digits for the next acquisition.
        err_nx   = 1'b1;
        state_nx = ACQUIRE;
      end else begin
        // Both acquisition and tracking adopt the observed value; in TRACK a
        // mismatch is a resync so one disturbance costs exactly one error.
        prev_nx  = count_in;
        units_nx = count_in;
        sel_nx   = sel_in;
        state_nx = TRACK;
        if (state == TRACK) begin
          if (count_in == exp_val) begin
            if (!sel_prev && prev == DIGIT_MAX && count_in == 4'd0) begin
              wrap_up_nx = 1'b1;
              tens_nx    = bcd_step(tens, 1'b0);
            end else if (sel_prev && prev == 4'd0 && count_in == DIGIT_MAX) begin
              wrap_dn_nx = 1'b1;
              tens_nx    = bcd_step(tens, 1'b1);
            end
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      if (err_nx && (err_count != {ERR_W{1'b1}}))
        err_count_nx = err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev      <= 4'd0;
      sel_prev  <= 1'b0;
      units     <= 4'd0;
      tens      <= 4'd0;
      err       <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      err_count <= '0;
    end else begin
      prev      <= prev_nx;
      sel_prev  <= sel_nx;
      units     <= units_nx;
      tens      <= tens_nx;
      err       <= err_nx;
      wrap_up   <= wrap_up_nx;
      wrap_dn   <= wrap_dn_nx;
      err_count <= err_count_nx;
    end
  end

`ifdef DECADE_MON_SEG_EN
  logic [6:0] seg_units_nx, seg_tens_nx;

  // Decode the next-state digits so the display changes with the digit.
  bcd_to_seg7 u_seg_units (.digit(units_nx), .seg(seg_units_nx));
  bcd_to_seg7 u_seg_tens  (.digit(tens_nx),  .seg(seg_tens_nx));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_units <= SEG_BLANK_ZERO;
      seg_tens  <= SEG_BLANK_ZERO;
    end else begin
      seg_units <= seg_units_nx;
      seg_tens  <= seg_tens_nx;
    end
  end
`endif

endmodule

// File: tb/tb_decade_count_monitor.sv
// tb_decade_count_monitor: directed self-checking bench for decade_count_monitor.
module tb_decade_count_monitor;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sample_en = 1'b0;
  logic [3:0]       count_in = 4'd0;
  logic             sel_in = 1'b0;
  logic [3:0]       tens, units;
  logic             locked, err, wrap_up, wrap_dn;
  logic [ERR_W-1:0] err_count;
`ifdef DECADE_MON_SEG_EN
  logic [6:0]       seg_units, seg_tens;
`endif

  decade_count_monitor #(.ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .count_in(count_in),
    .sel_in(sel_in), .tens(tens), .units(units), .locked(locked), .err(err),
    .err_count(err_count), .wrap_up(wrap_up),
`ifdef DECADE_MON_SEG_EN
    .wrap_dn(wrap_dn), .seg_units(seg_units), .seg_tens(seg_tens)
`else
    .wrap_dn(wrap_dn)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample, let it be taken on the edge, settle past the edge.
  task automatic smp(input logic [3:0] c, input logic s);
    sample_en = 1'b1;
    count_in  = c;
    sel_in    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tens"},   32'(tens), 32'd0);
    chk({tag, "_units"},  32'(units), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_err"},    32'(err), 32'd0);
    chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
    chk({tag, "_wup"},    32'(wrap_up), 32'd0);
    chk({tag, "_wdn"},    32'(wrap_dn), 32'd0);
`ifdef DECADE_MON_SEG_EN
    chk({tag, "_segu"},   32'(seg_units), 32'h3F);
    chk({tag, "_segt"},   32'(seg_tens), 32'h3F);
`endif
  endtask

  logic [3:0] up_seq [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
  logic [3:0] dn_seq [5]  = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};

  initial begin
    int ne;
    int nw;

    #2;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;

    // Up-count 0..9,0,1
    ne = 0; nw = 0;
    for (int i = 0; i < 12; i++) begin
      smp(up_seq[i], 1'b0);
      if (i == 0)  chk("up_lock_first", 32'(locked), 32'd1);
      if (i == 10) chk("up_wrap_at_9to0", 32'(wrap_up), 32'd1);
      ne += int'(err);
      nw += int'(wrap_up);
    end
    chk("up_errs", 32'(ne), 32'd0);
    chk("up_wraps", 32'(nw), 32'd1);
    chk("up_tens", 32'(tens), 32'd1);
    chk("up_units", 32'(units), 32'd1);
`ifdef DECADE_MON_SEG_EN
    chk("up_segu", 32'(seg_units), 32'h06);
    chk("up_segt", 32'(seg_tens), 32'h06);
`endif

    // Down-count 2,1,0,9,8; first sample is still an up-step from 1
    ne = 0; nw = 0;
    for (int i = 0; i < 5; i++) begin
      smp(dn_seq[i], 1'b1);
      if (i == 3) chk("dn_wrap_at_0to9", 32'(wrap_dn), 32'd1);
      ne += int'(err);
      nw += int'(wrap_dn);
    end
    chk("dn_errs", 32'(ne), 32'd0);
    chk("dn_wraps", 32'(nw), 32'd1);
    chk("dn_tens", 32'(tens), 32'd0);
    chk("dn_units", 32'(units), 32'd8);

    // Fresh start: 3,4,7,8 gives one out-of-sequence error then resync
    reset = 1'b0; #2; reset = 1'b1;
    smp(4'd3, 1'b0);
    chk("seq_acq_noerr", 32'(err), 32'd0);
    smp(4'd4, 1'b0);
    smp(4'd7, 1'b0);
    chk("seq_err7", 32'(err), 32'd1);
    chk("seq_cnt7", 32'(err_count), 32'd1);
    chk("seq_units7", 32'(units), 32'd7);
    smp(4'd8, 1'b0);
    chk("seq_noerr8", 32'(err), 32'd0);
    chk("seq_cnt8", 32'(err_count), 32'd1);

    // Build tens=1, then inject a non-BCD value and relock
    smp(4'd9, 1'b0);
    smp(4'd0, 1'b0);
    chk("inj_pre_tens", 32'(tens), 32'd1);
    smp(4'hC, 1'b0);
    chk("inj_err", 32'(err), 32'd1);
    chk("inj_unlock", 32'(locked), 32'd0);
    chk("inj_cnt", 32'(err_count), 32'd2);
    chk("inj_units_held", 32'(units), 32'd0);
    smp(4'd5, 1'b1);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_noerr", 32'(err), 32'd0);
    chk("relock_tens", 32'(tens), 32'd1);
    chk("relock_units", 32'(units), 32'd5);

    // sample_en low: nothing moves, no pulses
    sample_en = 1'b0;
    count_in  = 4'hF;
    @(posedge clk); #1;
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_locked", 32'(locked), 32'd1);
    chk("idle_units", 32'(units), 32'd5);

    // Saturation: 260 illegal samples from err_count=2
    ne = 0;
    for (int i = 0; i < 260; i++) begin
      smp(4'hF, 1'b0);
      ne += int'(err);
    end
    chk("sat_pulses", 32'(ne), 32'd260);
    chk("sat_cnt", 32'(err_count), 32'd255);
    chk("sat_unlock", 32'(locked), 32'd0);

    // Count to tens=3 then reset asynchronously mid-cycle
    reset = 1'b0; #2; reset = 1'b1;
    for (int i = 0; i < 33; i++) smp(4'(i % 10), 1'b0);
    chk("mid_tens", 32'(tens), 32'd3);
    chk("mid_units", 32'(units), 32'd2);
`ifdef DECADE_MON_SEG_EN
    chk("mid_segt", 32'(seg_tens), 32'h4F);
`endif
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
